// File: rtl/fib_pkg.sv
// Shared constants and the scheduler FSM state type for the Fibonacci engine.
package fib_pkg;

  // Largest legal index: fib(46) = 1836311903 is the largest value below 2^31.
  localparam int N_MAX = 46;
  localparam int N_W   = 8;
  localparam int Y_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fib_engine.sv
// Iterative Fibonacci engine: start loads a=0, b=1, cnt=n; each cycle after
// that advances the pair once until cnt reaches zero, at which point done is
// high for one cycle and y holds fib(n).
module fib_engine
  import fib_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] n,
  output logic           done,
  output logic [Y_W-1:0] y
);

  logic [Y_W-1:0] a_q;
  logic [Y_W-1:0] b_q;
  logic [N_W-1:0] cnt_q;
  logic           active_q;

  // Load on start, then step the a/b pair once per cycle while counting down.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      a_q      <= '0;
      b_q      <= Y_W'(1);
      cnt_q    <= n;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments make b_q <= a_q + b_q see the old a_q,
        // so the pair advances without a temporary.
        a_q   <= b_q;
        b_q   <= a_q + b_q;
        cnt_q <= cnt_q - N_W'(1);
      end
    end
  end

  assign done = active_q && (cnt_q == '0);
  assign y    = a_q;

endmodule

// File: rtl/fib_sched.sv
// Round-robin front end that shares one fib_engine among NREQ requesters.
// IDLE grants one requester, RUN waits for the engine (skipped for illegal n),
// DONE presents the result until the consumer takes it.
module fib_sched
  import fib_pkg::N_W, fib_pkg::Y_W, fib_pkg::state_e;
  import fib_pkg::ST_IDLE, fib_pkg::ST_RUN, fib_pkg::ST_DONE;
#(
  parameter  int NREQ  = 4,
  parameter  int N_MAX = fib_pkg::N_MAX,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*N_W-1:0]  req_n,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [Y_W-1:0]       rsp_y,
  output logic                 rsp_err,
  input  logic                 rsp_ready,
  output logic                 busy
);

  localparam logic [N_W-1:0] N_MAX_N = N_W'(N_MAX);

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_grant_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [Y_W-1:0]  rsp_y_q;
  logic            rsp_err_q;

  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [N_W-1:0]  grant_n;
  logic            n_illegal;
  logic            accept;
  logic            eng_start;
  logic            eng_done;
  logic [Y_W-1:0]  eng_y;

  // Requester index k+1 places after last, wrapping at NREQ.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] last, input int k);
    int sum;
    sum = int'(last) + 1 + k;
    if (sum >= NREQ) sum -= NREQ;
    return ID_W'(sum);
  endfunction

  // Round-robin search: first valid requester at or after last_grant+1.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && req_valid[rr_index(last_grant_q, k)]) begin
        grant_found = 1'b1;
        grant_id    = rr_index(last_grant_q, k);
      end
    end
  end

  assign grant_n   = req_n[int'(grant_id)*N_W +: N_W];
  assign n_illegal = (grant_n > N_MAX_N);

  // Next state and handshake strobes; req_ready is forced low while in reset.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    eng_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!reset && grant_found) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
          eng_start           = !n_illegal;
          state_d             = n_illegal ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (eng_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Capture the owner on accept and the result when the engine finishes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= ID_W'(NREQ - 1);
      rsp_id_q     <= '0;
      rsp_y_q      <= '0;
      rsp_err_q    <= 1'b0;
    end else if (accept) begin
      last_grant_q <= grant_id;
      rsp_id_q     <= grant_id;
      rsp_err_q    <= n_illegal;
      rsp_y_q      <= '0;
    end else if (state_q == ST_RUN && eng_done) begin
      rsp_y_q   <= eng_y;
      rsp_err_q <= 1'b0;
    end
  end

  fib_engine u_engine (
    .clock (clock),
    .reset (reset),
    .start (eng_start),
    .n     (grant_n),
    .done  (eng_done),
    .y     (eng_y)
  );

  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/fib_sched.md
FIB_SCHED -- requirements
Module: fib_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the Fibonacci engine.
REQ-002 Parameter N_MAX, default 46: largest legal index, since fib(46)=1836311903 is the largest value below 2^31.
REQ-003 clock  in  1  system clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  NREQ  per-requester request valid.
REQ-006 req_n  in  NREQ*8  per-requester index n; requester i uses bits [8i+7:8i].
REQ-007 req_ready  out  NREQ  one-hot grant/accept strobe.
REQ-008 rsp_valid  out  1  result valid.
REQ-009 rsp_id  out  $clog2(NREQ)  index of the requester that owns the result.
REQ-010 rsp_y  out  32  fib(n), unsigned.
REQ-011 rsp_err  out  1  n > N_MAX; rsp_y is 0 when this is set.
REQ-012 rsp_ready  in  1  consumer accepts the result.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states are IDLE, RUN and DONE.
REQ-015 In IDLE, req_ready SHALL be 0 when no req_valid bit is set.
REQ-016 In IDLE with any req_valid bit set, req_ready SHALL assert combinationally for exactly one requester g, chosen round-robin as the first valid requester at or after last_grant+1, wrapping at NREQ.
REQ-017 On accept (IDLE, req_valid[g] and req_ready[g] both high), the block SHALL capture n and g, set last_grant to g, load a=0, b=1 and cnt=n, and move to RUN; when n > N_MAX it SHALL move to DONE instead, with rsp_err=1 and rsp_y=0.
REQ-018 In RUN, if cnt==0 the block SHALL latch rsp_y=a and rsp_err=0 and move to DONE; otherwise it SHALL update a<=b, b<=a+b (32-bit, wrap unobservable for n<=46) and cnt<=cnt-1.
REQ-019 Latency for a legal n: rsp_valid SHALL first be high in cycle n+2 after the accept cycle, so fib(0) appears in cycle 2 and fib(46) in cycle 48.
REQ-020 Latency for an illegal n: rsp_valid SHALL be high in cycle 1 after the accept cycle.
REQ-021 In DONE, rsp_valid=1, and rsp_y, rsp_id and rsp_err SHALL hold stable until rsp_ready is high; on that edge the block SHALL return to IDLE.
REQ-022 No new request SHALL be accepted in the cycle the response handshake occurs; there is at least one IDLE cycle between jobs.
REQ-023 req_ready SHALL be 0 in RUN and DONE, and requesters SHALL hold req_valid and req_n until granted.
REQ-024 Changes to req_n or req_valid for the active job after its accept SHALL have no effect on that job.
REQ-025 A single requester that is continuously valid SHALL be re-granted whenever no other requester is valid.

Reset
REQ-026 reset SHALL force, immediately: state=IDLE, rsp_valid=0, rsp_y=0, rsp_id=0, rsp_err=0, busy=0, req_ready=0, and last_grant=NREQ-1 so that requester 0 has first priority.
REQ-027 Reset mid-job SHALL abandon the job, and no response for it SHALL ever be produced.

Structure
REQ-028 Package fib_pkg SHALL hold N_MAX, the width constants (N_W=8, Y_W=32) and the FSM state enum type.
REQ-029 The a/b/cnt iterator SHALL be a sub-module fib_engine with ports start, n, done and y.
REQ-030 Arbitration and handshaking SHALL live in fib_sched.

Verification
REQ-031 Scenario: requester 2 sends n=10, rsp_ready held high -> rsp_valid in cycle 12 after accept, rsp_y=55, rsp_id=2, rsp_err=0.
REQ-032 Scenario: n=1, n=2, n=46, then n=0 in sequence -> results 1, 1, 1836311903, 0; 0 arrives in cycle 2 after its accept.
REQ-033 Scenario: n=47 -> rsp_valid in cycle 1 after accept, rsp_y=0, rsp_err=1; n=255 gives the same result.
REQ-034 Scenario: after reset, all 4 requesters valid with n=5,6,7,8 -> grant order 0,1,2,3 and results 5,8,13,21; then requesters 0 and 3 re-request -> 0 is granted before 3.
REQ-035 Scenario: rsp_ready held low for 20 cycles on n=20 -> rsp_y=6765 and rsp_id are held stable throughout, busy=1, and every req_ready bit stays 0.
REQ-036 Scenario: reset asserted in RUN, 5 cycles after accept of n=30 -> outputs zero immediately, no response appears, and the next request n=3 returns 2.
REQ-037 Scenario: the DPI model loop, n=1..46 repeated over 1000 passes -> zero mismatches against the golden table.
